// File: rtl/seg7_capture.sv
// seg7_capture: recovers hex digits from a multiplexed active-low seven-segment bus.
// Latency: a pattern stable before edge e1 updates the outputs at edge e(STABLE_CYCLES+2).
// Backpressure: none; this is a passive monitor and every sample is consumed.
module seg7_capture #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4   // must be at least 2
) (
    input  logic                  clk,
    input  logic                  clr_n,
    input  logic [DIGITS-1:0]     an,
    input  logic [6:0]            a_to_g,
    output logic [4*DIGITS-1:0]   value,
    output logic [DIGITS-1:0]     digit_valid,
    output logic                  frame_done,
    output logic                  err,
    output logic [7:0]            err_cnt
);
    localparam int SW = DIGITS + 7;
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_PRE = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [SW-1:0]       samp_q, samp_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                acc_q, acc_d;
    logic [DIGITS-1:0]   seen_q, seen_d;
    logic [4*DIGITS-1:0] value_q, value_d;
    logic [DIGITS-1:0]   dv_q, dv_d;
    logic                frame_q, frame_d;
    logic                err_q, err_d;
    logic [7:0]          err_cnt_q, err_cnt_d;

    logic                match;
    logic [DIGITS-1:0]   an_r;
    logic [6:0]          seg_r;
    logic                sel_one;
    logic                dec_ok;
    logic [3:0]          dec_nib;

    // Inverse of the board glyph table; returns {ok, nibble}, ok=0 for non-hex glyphs.
    function automatic logic [4:0] decode(input logic [6:0] seg);
        logic [4:0] res;
        res = 5'b0_0000;
        case (seg)
            7'b0000001: res = 5'h10;
            7'b1001111: res = 5'h11;
            7'b0010010: res = 5'h12;
            7'b0000110: res = 5'h13;
            7'b1001100: res = 5'h14;
            7'b0100100: res = 5'h15;
            7'b0100000: res = 5'h16;
            7'b0001111: res = 5'h17;
            7'b0000000: res = 5'h18;
            7'b0000100: res = 5'h19;
            7'b0001000: res = 5'h1A;
            7'b1100000: res = 5'h1B;
            7'b0110001: res = 5'h1C;
            7'b1000010: res = 5'h1D;
            7'b0110000: res = 5'h1E;
            7'b0111000: res = 5'h1F;
            default:    res = 5'h00;
        endcase
        return res;
    endfunction

    // Stability filter: count consecutive identical samples, fire accept once on reaching the limit.
    always_comb begin
        samp_d = {an, a_to_g};
        match  = (samp_d == samp_q);
        cnt_d  = '0;
        acc_d  = 1'b0;
        if (match) begin
            cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;
            acc_d = (cnt_q == CNT_PRE);
        end
    end

    assign {an_r, seg_r}    = samp_q;
    assign {dec_ok, dec_nib} = decode(seg_r);
    assign sel_one          = $onehot(~an_r);

    // Act on an accepted pattern: decode into the selected digit, track frame progress and errors.
    always_comb begin
        frame_d   = &seen_q;
        seen_d    = frame_d ? '0 : seen_q;
        value_d   = value_q;
        dv_d      = dv_q;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;
        if (acc_q && sel_one) begin
            for (int k = 0; k < DIGITS; k++) begin
                if (!an_r[k]) begin
                    // An errored digit still counts as seen for the frame.
                    seen_d[k] = 1'b1;
                    if (dec_ok) begin
                        value_d[4*k +: 4] = dec_nib;
                        dv_d[k]           = 1'b1;
                    end else begin
                        dv_d[k]           = 1'b0;
                    end
                end
            end
            if (!dec_ok) begin
                err_d = 1'b1;
                if (err_cnt_q != 8'hFF) begin
                    err_cnt_d = err_cnt_q + 8'd1;
                end
            end
        end
    end

    // State registers; reset discards any partial frame.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            samp_q    <= '0;
            cnt_q     <= '0;
            acc_q     <= 1'b0;
            seen_q    <= '0;
            value_q   <= '0;
            dv_q      <= '0;
            frame_q   <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            samp_q    <= samp_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            seen_q    <= seen_d;
            value_q   <= value_d;
            dv_q      <= dv_d;
            frame_q   <= frame_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign value       = value_q;
    assign digit_valid = dv_q;
    assign frame_done  = frame_q;
    assign err         = err_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_seg7_capture.sv
// tb_seg7_capture: directed and random scans of the seven-segment bus against a reference model.
// Latency: model predicts outputs edge by edge; outputs sampled 1 time unit after each rising edge.
// Backpressure: none; inputs are driven freely every cycle.
module tb_seg7_capture;
    localparam int S = 4;

    logic        clk = 1'b0;
    logic        clr_n;
    logic [3:0]  an_s;
    logic [6:0]  seg_s;
    logic [15:0] value;
    logic [3:0]  digit_valid;
    logic        frame_done;
    logic        err;
    logic [7:0]  err_cnt;

    seg7_capture #(.DIGITS(4), .STABLE_CYCLES(S)) dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .an          (an_s),
        .a_to_g      (seg_s),
        .value       (value),
        .digit_valid (digit_valid),
        .frame_done  (frame_done),
        .err         (err),
        .err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    // Board glyph table, index = nibble.
    logic [6:0] glyph [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                               7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    int n_chk = 0;
    int n_err = 0;
    int n_frame = 0;
    int n_errp = 0;

    // Reference model state.
    logic [10:0] m_prev;
    int          m_run;
    logic        m_pend;
    logic [10:0] m_pat;
    logic [15:0] m_value;
    logic [3:0]  m_dv;
    logic [3:0]  m_seen;
    logic        m_frame;
    logic        m_err;
    int          m_errcnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_prev = '0; m_run = 0; m_pend = 1'b0; m_pat = '0;
        m_value = '0; m_dv = '0; m_seen = '0; m_frame = 1'b0; m_err = 1'b0; m_errcnt = 0;
    endtask

    // Search the glyph table: {found, nibble}.
    function automatic logic [4:0] lookup(input logic [6:0] g);
        logic [4:0] r;
        r = 5'h00;
        for (int i = 0; i < 16; i++) begin
            if (glyph[i] == g) r = {1'b1, 4'(i)};
        end
        return r;
    endfunction

    // Advance the model by one rising edge with the inputs present at that edge.
    task automatic model_edge();
        logic [10:0] cur;
        logic [3:0]  lo;
        logic [4:0   ] lk;
        int          dig;
        cur     = {an_s, seg_s};
        m_frame = (m_seen == 4'hF);
        if (m_frame) m_seen = 4'h0;
        m_err   = 1'b0;
        if (m_pend) begin
            lo = ~m_pat[10:7];
            if ($countones(lo) == 1) begin
                dig = 0;
                for (int k = 0; k < 4; k++) if (lo[k]) dig = k;
                lk = lookup(m_pat[6:0]);
                m_seen[dig] = 1'b1;
                if (lk[4]) begin
                    m_value[4*dig +: 4] = lk[3:0];
                    m_dv[dig] = 1'b1;
                end else begin
                    m_dv[dig] = 1'b0;
                    m_err = 1'b1;
                    m_errcnt = (m_errcnt >= 255) ? 255 : m_errcnt + 1;
                end
            end
        end
        if (cur == m_prev) m_run++;
        else               m_run = 0;
        m_pend = (m_run == S);
        m_pat  = cur;
        m_prev = cur;
    endtask

    task automatic step(input logic [3:0] a, input logic [6:0] g);
        an_s  = a;
        seg_s = g;
        @(posedge clk);
        model_edge();
        #1;
        chk("value", value, m_value);
        chk("digit_valid", digit_valid, m_dv);
        chk("frame_done", frame_done, m_frame);
        chk("err", err, m_err);
        chk("err_cnt", err_cnt, m_errcnt);
        if (frame_done) n_frame++;
        if (err) n_errp++;
    endtask

    task automatic hold(input logic [3:0] a, input logic [6:0] g, input int n);
        repeat (n) step(a, g);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 clr_n = 1'b0;
        model_reset();
        repeat (3) begin
            an_s  = 4'($urandom);
            seg_s = 7'($urandom);
            @(negedge clk);
        end
        chk("rst_value", value, 0);
        chk("rst_digit_valid", digit_valid, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_err", err, 0);
        chk("rst_err_cnt", err_cnt, 0);
        an_s  = 4'hF;
        seg_s = 7'h7F;
        clr_n = 1'b1;
    endtask

    initial begin
        int          base_f, base_e, nchg, chg_at, upd_at, fr_at;
        logic [15:0] pv;
        logic        saw8;
        logic [3:0]  ra;
        logic [6:0]  rg;
        clr_n = 1'b0;
        an_s  = 4'hF;
        seg_s = 7'h7F;
        model_reset();

        // Reset and idle with a blanked display.
        do_reset();
        base_f = n_frame; base_e = n_errp;
        hold(4'hF, 7'h7F, 100);
        chk("idle_pulses", n_frame + n_errp - base_f - base_e, 0);

        // Single digit 'A' on digit 0, updated exactly once at the sixth edge.
        pv = value; nchg = 0; chg_at = -1;
        for (int i = 0; i < 20; i++) begin
            step(4'hE, 7'b0001000);
            if (value != pv) begin nchg++; chg_at = i; end
            pv = value;
        end
        chk("single_value", value, 16'h000A);
        chk("single_dv", digit_valid, 4'b0001);
        chk("single_changes", nchg, 1);
        chk("single_edge", chg_at, 5);

        // Full frame 3,5,B,F.
        base_f = n_frame;
        hold(4'hE, 7'b0000110, 8);
        hold(4'hD, 7'b0100100, 8);
        hold(4'hB, 7'b1100000, 8);
        upd_at = -1; fr_at = -1; pv = value;
        for (int i = 0; i < 8; i++) begin
            step(4'h7, 7'b0111000);
            if (value[15:12] != pv[15:12]) upd_at = i;
            if (frame_done) fr_at = i;
            pv = value;
        end
        chk("frame_value", value, 16'hFB53);
        chk("frame_dv", digit_valid, 4'hF);
        chk("frame_pulses", n_frame - base_f, 1);
        chk("frame_after_update", fr_at - upd_at, 1);

        // Glitch: an '8' held too briefly must never appear.
        saw8 = 1'b0;
        for (int i = 0; i < 13; i++) begin
            step(4'hD, (i < 3) ? 7'b0000000 : 7'b1001111);
            if (value[7:4] == 4'h8) saw8 = 1'b1;
        end
        chk("glitch_value", value[7:4], 4'h1);
        chk("glitch_saw8", saw8, 1'b0);

        // Undecodable pattern on digit 3, then drive the counter into saturation.
        base_e = n_errp;
        hold(4'h7, 7'h7F, 10);
        chk("err_pulses", n_errp - base_e, 1);
        chk("err_cnt_one", err_cnt, 1);
        chk("err_dv3", digit_valid[3], 1'b0);
        chk("err_value_held", value[15:12], 4'hF);
        for (int i = 0; i < 300; i++) begin
            hold(4'hF, 7'h7F, 1);
            hold(4'h7, 7'h7F, 6);
        end
        chk("err_cnt_sat", err_cnt, 255);
        chk("err_pulses_all", n_errp - base_e, 301);

        // Multi-select is ignored.
        pv = value; base_e = n_errp;
        hold(4'b1100, 7'b0000001, 10);
        chk("multi_value", value, pv);
        chk("multi_err", n_errp - base_e, 0);

        // Reset mid-frame discards progress.
        do_reset();
        hold(4'hE, glyph[7], 8);
        hold(4'hD, glyph[9], 8);
        chk("pre_reset_value", value, 16'h0097);
        do_reset();
        base_f = n_frame;
        hold(4'hB, glyph[2], 8);
        hold(4'h7, glyph[12], 8);
        hold(4'hF, 7'h7F, 6);
        chk("midreset_no_frame", n_frame - base_f, 0);
        chk("midreset_value", value, 16'hC200);

        // Random scans against the model.
        do_reset();
        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 9))
                8:       ra = 4'hF;
                9:       ra = 4'($urandom);
                default: ra = ~(4'b0001 << $urandom_range(0, 3));
            endcase
            if ($urandom_range(0, 3) != 0) rg = glyph[$urandom_range(0, 15)];
            else                           rg = 7'($urandom);
            hold(ra, rg, $urandom_range(1, 10));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/seg7_capture.md
Name: seg7_capture

Overview:
- Inverse of the board's hex-to-seven-segment encoding: monitors a multiplexed 4-digit active-low seven-segment bus (anodes plus a_to_g) and recovers the displayed hex value.
- Sits beside the display driver as a self-check and loopback block for lab benches and on-board readback.
- Filters scan transitions with a stability counter and decodes each settled pattern back to a nibble.
- Flags patterns that are not valid hex glyphs and signals when every digit has been seen once.

Parameters:
- DIGITS, 4, number of multiplexed digits (width of `an`).
- STABLE_CYCLES, 4, consecutive identical samples required before a pattern is accepted (minimum 2).

Ports:
- `clk`  input  1  system clock, rising edge.
- `clr_n`  input  1  asynchronous active-low reset.
- `an`  input  DIGITS  digit enables, active-low; bit k selects digit k (digit 0 = least significant nibble).
- `a_to_g`  input  7  segment lines, active-low; bit 6 = a, bit 0 = g.
- `value`  output  4*DIGITS  decoded nibbles; `value[4k+3:4k]` belongs to digit k.
- `digit_valid`  output  DIGITS  bit k = 1 when the last accepted pattern for digit k decoded cleanly.
- `frame_done`  output  1  one-cycle pulse when all digits have been accepted since the previous pulse or reset.
- `err`  output  1  one-cycle pulse on acceptance of an undecodable pattern.
- `err_cnt`  output  8  count of err pulses, saturating at 255.

Behaviour:
- Reset (`clr_n` = 0, async): `value` = 0, `digit_valid` = 0, `frame_done` = 0, `err` = 0, `err_cnt` = 0. The sample register, stability counter, seen mask and accept flag are also cleared. Reset asserted mid-frame discards partial frame progress.
- Sampling: each edge, the sample register r <= {`an`, `a_to_g`}.
  - If the raw inputs equal r, cnt <= min(cnt+1, STABLE_CYCLES).
  - Otherwise cnt <= 0.
- Accept: an internal registered flag pulses for exactly one cycle on the edge where cnt becomes STABLE_CYCLES. It does not pulse again until the inputs change and re-settle. A pattern held indefinitely is therefore accepted once.
- Latency: if the inputs settle before edge e1, outputs update at edge e(STABLE_CYCLES+2). With the default of 4, this is the 6th edge.
- On accept, the state of r.an determines the action:
  - Exactly one bit low (digit k): decode r.a_to_g.
  - All ones (blanked) or more than one bit low: no output change, no error.
- Decode table (a_to_g to nibble):
  - 0000001 = 0, 1001111 = 1, 0010010 = 2, 0000110 = 3
  - 1001100 = 4, 0100100 = 5, 0100000 = 6, 0001111 = 7
  - 0000000 = 8, 0000100 = 9, 0001000 = A, 1100000 = B
  - 0110001 = C, 1000010 = D, 0110000 = E, 0111000 = F
- Valid decode: `value[4k+3:4k]` <= nibble, `digit_valid[k]` <= 1, seen[k] <= 1.
- Invalid pattern:
  - `value` nibble k is held.
  - `digit_valid[k]` <= 0.
  - `err` = 1 for one cycle.
  - `err_cnt` <= `err_cnt` + 1, saturating at 255 (no wrap).
  - seen[k] <= 1; an errored digit still counts toward the frame.
- Frame:
  - When seen becomes all ones, `frame_done` = 1 on the next edge and seen clears on that same edge.
  - Repeat acceptances of an already-seen digit do not advance the frame.
  - Digits may arrive in any order.
- Simultaneous events: `err` and `frame_done` may assert in the same cycle. `frame_done` takes no account of errors; `digit_valid` reports error status.

Test Plan:
- Reset/idle: assert `clr_n` = 0 with random inputs, then release with `an` = 1111 -> all outputs 0, no pulses for 100 cycles.
- Single digit:
  - Stimulus: `an` = 1110, `a_to_g` = 0001000 (A), held for 20 cycles.
  - Required: `value` = 16'h000A, `digit_valid` = 0001 at edge 6 after settling, updated exactly once.
- Full frame:
  - Stimulus: scan digits 0..3 with patterns 0000110, 0100100, 1100000, 0111000, each held 8 cycles.
  - Required: `value` = 16'hFB53, `digit_valid` = 1111, one `frame_done` pulse one cycle after the digit-3 update.
- Glitch rejection:
  - Stimulus: `an` = 1101, `a_to_g` = 0000000 held for 3 cycles, then changed to 1001111 and held.
  - Required: only 1 is accepted; `value[7:4]` = 1 and never 8.
- Error path:
  - Stimulus: `an` = 0111, `a_to_g` = 1111111 held.
  - Required: `err` pulses once, `err_cnt` = 1, `digit_valid[3]` = 0, `value[15:12]` held.
  - Continuation: repeat the error 300 times with re-settling -> `err_cnt` saturates at 255.
- Multi-select/reset mid-frame:
  - Stimulus: `an` = 1100 held -> no update, no `err`.
  - Stimulus: accept digits 0 and 1, pulse `clr_n` low, then accept digits 2 and 3 only.
  - Required: `value` = 0 at reset, then no `frame_done` pulse.
